multicycle_sequencer: RTL
=========================

Name: multicycle_sequencer

Overview:
Multicycle main-control FSM for the MIPS datapath. It replaces externally stepped state counting with a self-sequencing controller. Each cycle it drives every datapath enable and select: PC, IR, data register, A/B operand registers, ALUOut, register file, memory and the jump mux. It adds a memory-ready stall handshake, fault trapping and a retired-instruction counter.

Parameters:
DATA_WIDTH, 32, width of the retired-instruction counter.
STALL_TIMEOUT, 16, consecutive cycles without mem_ready before a timeout fault is raised.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
Opcode  input  6  instruction [31:26] from the IR.
Funct  input  6  instruction [5:0] from the IR.
Zero  input  1  ALU zero flag, combinational.
mem_ready  input  1  memory has completed the current access.
aligment_error  input  1  virtual-memory alignment fault.
IorD  output  1  memory address select: 0=PC, 1=ALUOut.
Mem_select  output  1  0=ROM, 1=RAM.
MemWrite  output  1  RAM write enable.
IRWrite  output  1  IR load enable.
DataWrite  output  1  data register load enable.
RDx_FF_en  output  1  A/B register load enable.
RegDst  output  1  register destination: 0=rt, 1=rd.
MemtoReg  output  1  write-back source: 0=ALUOut, 1=data register.
RegWrite  output  1  register file write enable.
ALUSrcA  output  1  0=PC, 1=A.
ALUSrcB  output  2  0=B, 1=4, 2=sign-extended immediate, 3=sign-extended immediate <<2.
ALUControl  output  4  ALU operation code.
ALUresult_en  output  1  ALUOut load enable.
PCSrc  output  1  0=ALUResult, 1=ALUOut.
flag_J_type  output  1  select jump address into PC.
PC_En  output  1  PC load enable.
fault  output  1  sticky; controller is in FAULT.
fault_code  output  2  0=none, 1=illegal opcode/funct, 2=alignment, 3=stall timeout.
instr_retired  output  DATA_WIDTH  count of completed instructions.
state_dbg  output  4  current state encoding.

Behaviour:
- Moore outputs are decoded from the state register. PC_En is the only exception: PC_En = PCWrite | (Branch & (Zero ^ is_bne)).
- Reset (synchronous): state=FETCH, fault=0, fault_code=0, instr_retired=0, stall counter=0.
- While reset is high, all enables, MemWrite, RegWrite and PC_En are 0.
- Unlisted outputs in any state are 0.
- FETCH:
  - Outputs: IorD=0, Mem_select=0, ALUSrcA=0, ALUSrcB=1, ALUControl=ADD, PCSrc=0.
  - While mem_ready=0: hold, with IRWrite=0 and PCWrite=0.
  - When mem_ready=1: IRWrite=1, PCWrite=1 (PC<=PC+4), then go to DECODE.
- DECODE:
  - Outputs: RDx_FF_en=1, ALUSrcA=0, ALUSrcB=3, ALUControl=ADD, ALUresult_en=1 (branch target).
  - Dispatch on Opcode: 0x00 to EXEC_R; 0x23 or 0x2B to MEMADR; 0x04 or 0x05 to BRANCH; 0x08 to ADDI_EX; 0x02 to JUMP; any other value to FAULT with code 1.
- EXEC_R:
  - Outputs: ALUSrcA=1, ALUSrcB=0, ALUControl from Funct, ALUresult_en=1, then go to ALU_WB.
  - Funct decode: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x00 SLL, 0x02 SRL. Any other Funct goes to FAULT with code 1.
- ALU_WB: RegDst=1, MemtoReg=0, RegWrite=1, then retire and go to FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUControl=ADD, ALUresult_en=1. Go to MEMRD if Opcode=0x23, else MEMWR.
- MEMRD: IorD=1, Mem_select=1, DataWrite=mem_ready. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1, then retire and go to FETCH.
- MEMWR: IorD=1, Mem_select=1, MemWrite=1 throughout the hold. On mem_ready, retire and go to FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=0, ALUControl=SUB, PCSrc=1, Branch=1.
  - is_bne=(Opcode==0x05).
  - Retire and go to FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=2, ALUControl=ADD, ALUresult_en=1, then go to ADDI_WB.
- ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1, then retire and go to FETCH.
- JUMP: flag_J_type=1, PCWrite=1, then retire and go to FETCH.
- Retire: instr_retired increments by 1 on the cycle the state leaves for FETCH. It wraps modulo 2^DATA_WIDTH.
- Alignment fault: aligment_error sampled high in FETCH, MEMRD or MEMWR goes to FAULT with code 2. No write, IRWrite or PC update occurs in that cycle.
- Stall timeout:
  - The counter increments each cycle mem_ready=0 in a memory state and clears on mem_ready=1 or on a state change.
  - Reaching STALL_TIMEOUT goes to FAULT with code 3.
  - mem_ready=1 arriving in the same cycle as the timeout wins, and the access completes.
- FAULT: all enables are 0 and fault=1. Only reset exits. The first fault_code recorded is kept.
- Latency with mem_ready always 1: R-type 4 cycles, lw 5, sw 4, addi 4, beq/bne 3, j 3.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum with 4-bit encoding;
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J;
  - funct constants;
  - ALU codes: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7, ALU_SLL=8, ALU_SRL=9;
  - ALUSrcB select constants;
  - fault codes.
- One sub-module, alu_funct_decoder: combinational Funct to ALUControl plus an illegal flag.

Test Plan:
- add $3,$1,$2 (0x00221820), mem_ready=1: states FETCH, DECODE, EXEC_R, ALU_WB. RegWrite=1 with RegDst=1 only in cycle 4. instr_retired goes 0 to 1.
- lw (0x8C220004) with mem_ready held low 3 cycles in MEMRD: MEMRD lasts 4 cycles. DataWrite=1 only in the last cycle. Total 8 cycles. MemtoReg=1 in MEM_WB.
- beq with Zero=1, then bne with Zero=1: PC_En=1 with PCSrc=1 in the beq BRANCH cycle. PC_En=0 in the bne BRANCH cycle.
- j (0x08000010): JUMP cycle asserts flag_J_type=1 and PC_En=1. Back to FETCH after 3 cycles.
- Opcode 0x3F, then separately Funct 0x3F: FAULT with fault_code=1 and all enables 0. Synchronous reset returns the FSM to FETCH with counters 0.
- sw with mem_ready=0 for 16 cycles: FAULT with code 3, MemWrite deasserted in FAULT. Separately, aligment_error=1 during FETCH: FAULT with code 2 and IRWrite never pulsed.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: states, opcodes,
// funct values, ALU operation codes, ALUSrcB selects and fault codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_ALU_WB  = 4'd3,
        S_MEMADR  = 4'd4,
        S_MEMRD   = 4'd5,
        S_MEM_WB  = 4'd6,
        S_MEMWR   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDI_EX = 4'd9,
        S_ADDI_WB = 4'd10,
        S_JUMP    = 4'd11,
        S_FAULT   = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SLL = 4'd8;
    localparam logic [3:0] ALU_SRL = 4'd9;

    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_ILLEGAL = 2'd1,
        FC_ALIGN   = 2'd2,
        FC_TIMEOUT = 2'd3
    } fault_e;

    // States that wait on the memory handshake and can stall or fault on alignment.
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/alu_funct_decoder.sv
// Maps the R-type Funct field onto an ALU operation code; unknown values
// raise illegal_o so the sequencer can trap.
module alu_funct_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output logic       illegal_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        illegal_o  = 1'b0;
        case (funct_i)
            FN_ADD:  alu_ctrl_o = ALU_ADD;
            FN_SUB:  alu_ctrl_o = ALU_SUB;
            FN_AND:  alu_ctrl_o = ALU_AND;
            FN_OR:   alu_ctrl_o = ALU_OR;
            FN_SLT:  alu_ctrl_o = ALU_SLT;
            FN_SLL:  alu_ctrl_o = ALU_SLL;
            FN_SRL:  alu_ctrl_o = ALU_SRL;
            default: illegal_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Self-sequencing multicycle MIPS main controller with memory-ready stalls,
// stall timeout and alignment trapping, and a retired-instruction counter.
module multicycle_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int STALL_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            Opcode,
    input  logic [5:0]            Funct,
    input  logic                  Zero,
    input  logic                  mem_ready,
    input  logic                  aligment_error,
    output logic                  IorD,
    output logic                  Mem_select,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  DataWrite,
    output logic                  RDx_FF_en,
    output logic                  RegDst,
    output logic                  MemtoReg,
    output logic                  RegWrite,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [3:0]            ALUControl,
    output logic                  ALUresult_en,
    output logic                  PCSrc,
    output logic                  flag_J_type,
    output logic                  PC_En,
    output logic                  fault,
    output logic [1:0]            fault_code,
    output logic [DATA_WIDTH-1:0] instr_retired,
    output logic [3:0]            state_dbg
);

    localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);

    state_e                state_q, state_d;
    fault_e                fault_code_q, fault_code_d;
    logic [CNT_W-1:0]      stall_q, stall_d;
    logic [DATA_WIDTH-1:0] retired_q;

    logic [3:0] funct_alu;
    logic       funct_illegal;
    logic       mem_state;
    logic       stall_expire;
    logic       retire;
    logic       pc_write;
    logic       branch;

    alu_funct_decoder u_funct_dec (
        .funct_i    (Funct),
        .alu_ctrl_o (funct_alu),
        .illegal_o  (funct_illegal)
    );

    assign mem_state    = is_mem_state(state_q);
    // Expiry is only decided on a cycle without mem_ready, so a late ready always wins.
    assign stall_expire = mem_state && !mem_ready && (stall_q == CNT_W'(STALL_TIMEOUT - 1));
    assign retire       = (state_d == S_FETCH) && (state_q != S_FETCH);

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        stall_d      = '0;
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:      state_d = S_EXEC_R;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:       state_d = S_ADDI_EX;
                    OP_J:          state_d = S_JUMP;
                    default: begin
                        state_d      = S_FAULT;
                        fault_code_d = FC_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R: begin
                if (funct_illegal) begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_ILLEGAL;
                end else begin
                    state_d = S_ALU_WB;
                end
            end
            S_MEMADR:  state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_ADDI_WB, S_JUMP: state_d = S_FETCH;
            S_FAULT:   state_d = S_FAULT;
            default:   state_d = S_FAULT;
        endcase

        // Alignment beats both completion and timeout in the memory states.
        if (mem_state && aligment_error) begin
            state_d      = S_FAULT;
            fault_code_d = FC_ALIGN;
        end else if (stall_expire) begin
            state_d      = S_FAULT;
            fault_code_d = FC_TIMEOUT;
        end else if (mem_state && !mem_ready) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            fault_code_q <= FC_NONE;
            stall_q      <= '0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            fault_code_q <= fault_code_d;
            stall_q      <= stall_d;
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

    always_comb begin
        IorD         = 1'b0;
        Mem_select   = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        DataWrite    = 1'b0;
        RDx_FF_en    = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_B;
        ALUControl   = ALU_AND;
        ALUresult_en = 1'b0;
        PCSrc        = 1'b0;
        flag_J_type  = 1'b0;
        pc_write     = 1'b0;
        branch       = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ALUSrcB    = SRCB_FOUR;
                    ALUControl = ALU_ADD;
                    IRWrite    = mem_ready && !aligment_error;
                    pc_write   = mem_ready && !aligment_error;
                end
                S_DECODE: begin
                    RDx_FF_en    = 1'b1;
                    ALUSrcB      = SRCB_IMM_SH2;
                    ALUControl   = ALU_ADD;
                    ALUresult_en = 1'b1;
                end
                S_EXEC_R: begin
                    ALUSrcA      = 1'b1;
                    ALUSrcB      = SRCB_B;
                    ALUControl   = funct_alu;
                    ALUresult_en = 1'b1;
                end
                S_ALU_WB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEMADR, S_ADDI_EX: begin
                    ALUSrcA      = 1'b1;
                    ALUSrcB      = SRCB_IMM;
                    ALUControl   = ALU_ADD;
                    ALUresult_en = 1'b1;
                end
                S_MEMRD: begin
                    IorD       = 1'b1;
                    Mem_select = 1'b1;
                    DataWrite  = mem_ready && !aligment_error;
                end
                S_MEM_WB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    IorD       = 1'b1;
                    Mem_select = 1'b1;
                    MemWrite   = !aligment_error;
                end
                S_BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = SRCB_B;
                    ALUControl = ALU_SUB;
                    PCSrc      = 1'b1;
                    branch     = 1'b1;
                end
                S_ADDI_WB: RegWrite = 1'b1;
                S_JUMP: begin
                    flag_J_type = 1'b1;
                    pc_write    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign PC_En         = pc_write | (branch & (Zero ^ (Opcode == OP_BNE)));
    assign fault         = (state_q == S_FAULT);
    assign fault_code    = fault_code_q;
    assign instr_retired = retired_q;
    assign state_dbg     = state_q;

endmodule
